// File: rtl/singly_linked_list_host.sv
// rtl/singly_linked_list_host.sv - host command sequencer driving one singly_linked_list instance
// Optional op_done watchdog is compiled in when LL_HOST_WATCHDOG_EN is defined.
module singly_linked_list_host #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_NODE    = 8,
  parameter int ADDR_WIDTH  = $clog2(MAX_NODE + 1),
  parameter int WDOG_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  resp_valid,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] resp_count,
  output logic [1:0]            ll_op,
  output logic [DATA_WIDTH-1:0] ll_data_in,
  output logic [ADDR_WIDTH-1:0] ll_addr_in,
  output logic                  ll_op_start,
  input  logic [DATA_WIDTH-1:0] ll_data_out,
  input  logic [ADDR_WIDTH-1:0] ll_next_node_addr,
  input  logic                  ll_op_done,
  input  logic [ADDR_WIDTH-1:0] ll_head,
  input  logic                  ll_empty,
  input  logic                  ll_fault
);

  localparam logic [ADDR_WIDTH-1:0] NULL_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(MAX_NODE);

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, RESP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] next_ptr;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_inc;
  logic                  fault;
  logic                  wdog_expired;

  assign count_inc = count + 1'b1;

`ifdef LL_HOST_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // Leaving ISSUE (to STREAM or RESP) clears the counter, so every list op gets a full budget.
  always_ff @(posedge clk) begin
    if (rst || state != ISSUE) wdog_cnt <= '0;
    else                       wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_expired = (state == ISSUE) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    ll_op_start = 1'b0;
    rd_valid    = 1'b0;
    resp_valid  = 1'b0;
    resp_fault  = 1'b0;
    resp_count  = '0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) state_next = (cmd_op == 2'd0 && ll_empty) ? RESP : ISSUE;
      end
      ISSUE: begin
        ll_op_start = !rst;
        if (ll_op_done)        state_next = (ll_op == 2'd0 && !ll_fault) ? STREAM : RESP;
        else if (wdog_expired) state_next = RESP;
      end
      STREAM: begin
        rd_valid = 1'b1;
        // A chain that never reaches NULL within MAX_NODE beats is treated as corrupt.
        if (rd_ready) state_next = (rd_last || count_inc == MAX_CNT) ? RESP : ISSUE;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault;
        resp_count = count;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ll_op      <= '0;
      ll_data_in <= '0;
      ll_addr_in <= NULL_ADDR;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      next_ptr   <= NULL_ADDR;
      count      <= '0;
      fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ll_op      <= cmd_op;
            ll_data_in <= cmd_data;
            if (cmd_op == 2'd0) ll_addr_in <= ll_head;
          end
        end
        ISSUE: begin
          if (ll_op_done) begin
            if (ll_fault) begin
              fault <= 1'b1;
            end else if (ll_op == 2'd0) begin
              rd_data  <= ll_data_out;
              next_ptr <= ll_next_node_addr;
              rd_last  <= (ll_next_node_addr == NULL_ADDR);
            end
          end else if (wdog_expired) begin
            fault <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_ready) begin
            count <= count_inc;
            if (!rd_last) begin
              if (count_inc == MAX_CNT) fault <= 1'b1;
              else                      ll_addr_in <= next_ptr;
            end
          end
        end
        RESP: begin
          fault <= 1'b0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_singly_linked_list_host.sv
// tb/tb_singly_linked_list_host.sv - self-checking bench for singly_linked_list_host with a queue-based list stub
`timescale 1ns/1ps
module tb_singly_linked_list_host;

  localparam int DW = 8, MN = 8, AW = 4, WD = 64;
  localparam logic [AW-1:0] NUL = '1;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rd_valid, rd_ready = 1'b0, rd_last;
  logic [1:0] cmd_op = '0, ll_op;
  logic [DW-1:0] cmd_data = '0, rd_data, ll_data_in, ll_data_out = '0;
  logic resp_valid, resp_fault, ll_op_start;
  logic [AW-1:0] resp_count, ll_addr_in, ll_next_node_addr = NUL, ll_head = NUL;
  logic ll_op_done = 1'b0, ll_empty = 1'b1, ll_fault = 1'b0;

  singly_linked_list_host #(.DATA_WIDTH(DW), .MAX_NODE(MN), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_count(resp_count),
    .ll_op(ll_op), .ll_data_in(ll_data_in), .ll_addr_in(ll_addr_in), .ll_op_start(ll_op_start),
    .ll_data_out(ll_data_out), .ll_next_node_addr(ll_next_node_addr), .ll_op_done(ll_op_done),
    .ll_head(ll_head), .ll_empty(ll_empty), .ll_fault(ll_fault));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // List stub: nodes live in a queue, address i is the i-th node in list order.
  logic [DW-1:0] mem[$];
  bit cyclic = 0, hang = 0;
  int lat = 1, lcnt = 0;

  task automatic stub_respond();
    int a, idx;
    a = int'(ll_addr_in);
    ll_fault = 1'b0;
    case (ll_op)
      2'd0: if (cyclic) begin
              ll_data_out = DW'(a); ll_next_node_addr = AW'((a + 1) % MN);
            end else if (a < mem.size()) begin
              ll_data_out = mem[a];
              ll_next_node_addr = (a + 1 < mem.size()) ? AW'(a + 1) : NUL;
            end else ll_fault = 1'b1;
      2'd1: begin
              idx = -1;
              foreach (mem[i]) if (idx < 0 && mem[i] == ll_data_in) idx = i;
              if (idx < 0) ll_fault = 1'b1; else mem.delete(idx);
            end
      2'd2: if (mem.size() < MN) mem.push_back(ll_data_in); else ll_fault = 1'b1;
      default: if (mem.size() < MN) mem.push_front(ll_data_in); else ll_fault = 1'b1;
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    if (ll_op_done) begin
      ll_op_done = 1'b0; lcnt = 0;
    end else if (ll_op_start && !hang) begin
      lcnt++;
      if (lcnt >= lat) begin
        stub_respond(); ll_op_done = 1'b1; lcnt = 0; lat = $urandom_range(1, 3);
      end
    end else lcnt = 0;
    ll_empty = cyclic ? 1'b0 : (mem.size() == 0);
    ll_head  = ll_empty ? NUL : '0;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model of list contents, derived from command semantics.
  logic [DW-1:0] ref_q[$];
  function automatic void ref_apply(input logic [1:0] op, input logic [DW-1:0] d,
                                    output logic f, output int c);
    int idx;
    f = 1'b0; c = 0;
    case (op)
      2'd0: c = ref_q.size();
      2'd1: begin
              idx = -1;
              for (int i = 0; i < ref_q.size(); i++) if (idx < 0 && ref_q[i] == d) idx = i;
              if (idx < 0) f = 1'b1; else ref_q.delete(idx);
            end
      2'd2: if (ref_q.size() < MN) ref_q.push_back(d); else f = 1'b1;
      default: if (ref_q.size() < MN) ref_q.push_front(d); else f = 1'b1;
    endcase
  endfunction

  logic [DW-1:0] exp_beats[$], beats[$];
  bit lasts[$];
  int t_valid, t_start, t_done, t_resp, n_rises, hold_bad, drop_bad, n_rdv, got_count;
  bit got_resp;
  logic got_fault, start_at_resp, rdy_after;

  function automatic logic ready_for(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] d, input int mode);
    logic prev_start, prev_done, prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    int budget;
    beats.delete(); lasts.delete();
    n_rises = 0; hold_bad = 0; drop_bad = 0; n_rdv = 0; got_resp = 0;
    t_start = -1; t_done = -1; t_resp = -1;
    prev_start = 0; prev_done = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    @(posedge clk); #2;
    budget = 0;
    while (!cmd_ready && budget < 200) begin @(posedge clk); #2; budget++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; t_valid = cyc;
    rd_ready = ready_for(mode, 0);
    for (int i = 0; i < 400 && !got_resp; i++) begin
      @(negedge clk);
      if (ll_op_start && !prev_start) begin n_rises++; if (t_start < 0) t_start = cyc; end
      if (prev_start && !ll_op_start && !prev_done) drop_bad++;
      if (ll_op_done) t_done = cyc;
      if (prev_stall && (!rd_valid || rd_data !== prev_data || rd_last !== prev_last)) hold_bad++;
      if (rd_valid) n_rdv++;
      if (rd_valid && rd_ready) begin beats.push_back(rd_data); lasts.push_back(rd_last); end
      prev_stall = rd_valid && !rd_ready; prev_data = rd_data; prev_last = rd_last;
      prev_start = ll_op_start; prev_done = ll_op_done;
      if (resp_valid) begin
        got_resp = 1; t_resp = cyc; got_fault = resp_fault; got_count = resp_count;
        start_at_resp = ll_op_start;
      end else begin
        @(posedge clk); #2;
        cmd_valid = 1'b0; rd_ready = ready_for(mode, i + 1);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rdy_after = cmd_ready;
  endtask

  task automatic check_result(input string nm, input logic[1:0] op, input logic ef, input int ec);
    chk($sformatf("%s resp_seen", nm), got_resp, 1);
    chk($sformatf("%s fault", nm), got_fault, ef);
    chk($sformatf("%s count", nm), got_count, ec);
    chk($sformatf("%s ready_after", nm), rdy_after, 1);
    chk($sformatf("%s start_low_in_resp", nm), start_at_resp, 0);
    chk($sformatf("%s hold", nm), hold_bad, 0);
    chk($sformatf("%s start_drop", nm), drop_bad, 0);
    if (op == 2'd0) begin
      chk($sformatf("%s beats", nm), beats.size(), exp_beats.size());
      for (int i = 0; i < beats.size() && i < exp_beats.size(); i++) begin
        chk($sformatf("%s data[%0d]", nm, i), beats[i], exp_beats[i]);
        chk($sformatf("%s last[%0d]", nm, i), lasts[i], (i == exp_beats.size() - 1) && !cyclic);
      end
    end else begin
      chk($sformatf("%s rises", nm), n_rises, 1);
      chk($sformatf("%s start_lat", nm), t_start, t_valid + 1);
      chk($sformatf("%s resp_lat", nm), t_resp, t_done + 1);
      chk($sformatf("%s no_rd", nm), n_rdv, 0);
    end
  endtask

  typedef struct {logic [1:0] op; logic [DW-1:0] d; int mode; logic ef; int ec;} vec_t;
  vec_t tbl[7];

  initial begin
    logic ef; int ec, cnt;
    logic [1:0] op; logic [DW-1:0] d;
    tbl[0] = '{2'd2, 8'h12, 0, 1'b0, 0};
    tbl[1] = '{2'd2, 8'h34, 0, 1'b0, 0};
    tbl[2] = '{2'd3, 8'h56, 0, 1'b0, 0};
    tbl[3] = '{2'd0, 8'h00, 0, 1'b0, 3};
    tbl[4] = '{2'd0, 8'h00, 1, 1'b0, 3};
    tbl[5] = '{2'd1, 8'h99, 0, 1'b1, 0};
    tbl[6] = '{2'd0, 8'h00, 2, 1'b0, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst outs", {rd_valid, rd_last, resp_valid, resp_fault, ll_op_start}, 0);
    chk("rst regs", {rd_data, resp_count, ll_op, ll_data_in}, 0);
    chk("rst addr", ll_addr_in, NUL);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post rst cmd_ready", cmd_ready, 1);

    foreach (tbl[k]) begin
      exp_beats = ref_q;
      ref_apply(tbl[k].op, tbl[k].d, ef, ec);
      run_cmd(tbl[k].op, tbl[k].d, tbl[k].mode);
      check_result($sformatf("vec%0d", k), tbl[k].op, tbl[k].ef, tbl[k].ec);
    end

    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      d = 8'h10 + 8'($urandom_range(0, 5));
      exp_beats = ref_q;
      ref_apply(op, d, ef, ec);
      run_cmd(op, d, $urandom_range(0, 2));
      check_result($sformatf("rnd%0d", k), op, ef, ec);
    end

    while (ref_q.size() > 0) begin
      d = ref_q[0];
      ref_apply(2'd1, d, ef, ec);
      run_cmd(2'd1, d, 0);
      check_result("drain", 2'd1, 1'b0, 0);
    end
    exp_beats.delete();
    run_cmd(2'd0, 8'h00, 0);
    check_result("empty trav", 2'd0, 1'b0, 0);
    chk("empty no_start", n_rises, 0);
    chk("empty no_rd", n_rdv, 0);
    chk("empty resp_lat", t_resp, t_valid + 1);

    cyclic = 1;
    exp_beats.delete();
    for (int i = 0; i < MN; i++) exp_beats.push_back(DW'(i));
    run_cmd(2'd0, 8'h00, 2);
    check_result("cyclic", 2'd0, 1'b1, MN);
    cyclic = 0;

`ifdef LL_HOST_WATCHDOG_EN
    hang = 1;
    run_cmd(2'd2, 8'hAA, 0);
    chk("wdog fault", got_fault, 1);
    chk("wdog time", t_resp - t_start, WD);
    hang = 0;
`endif

    for (int k = 0; k < 3; k++) begin
      d = 8'h40 + 8'(k);
      ref_apply(2'd2, d, ef, ec);
      run_cmd(2'd2, d, 0);
      check_result("refill", 2'd2, 1'b0, 0);
    end
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = 2'd0; rd_ready = 1'b0;
    @(posedge clk); #2 cmd_valid = 1'b0;
    cnt = 0;
    while (!rd_valid && cnt < 50) begin @(posedge clk); #2; cnt++; end
    chk("midrst reached stream", rd_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst start low now", ll_op_start, 0);
    @(negedge clk);
    chk("midrst outs", {rd_valid, rd_last, resp_valid, resp_fault, ll_op_start, cmd_ready}, 0);
    chk("midrst regs", {rd_data, resp_count, ll_op, ll_data_in}, 0);
    chk("midrst addr", ll_addr_in, NUL);
    @(posedge clk); #2 rst = 1'b0; rd_ready = 1'b1;
    cnt = 0;
    @(negedge clk);
    chk("midrst ready", cmd_ready, 1);
    repeat (10) begin @(negedge clk); if (resp_valid) cnt++; end
    chk("midrst no resp", cnt, 0);
    exp_beats = ref_q;
    run_cmd(2'd0, 8'h00, 0);
    check_result("after rst trav", 2'd0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/singly_linked_list_host.md
# singly_linked_list_host

Command initiator for `singly_linked_list`. It accepts high-level host commands: push back, push front, delete by value, and full-list traverse. It drives the list's `op`/`op_start`/`op_done` handshake and streams traversed node data out over a valid/ready port. It sits between a host/CPU-side agent and one list instance, and owns all list-side sequencing.

## Interface
- `DATA_WIDTH`, 8, node data width; must match the list instance.
- `MAX_NODE`, 8, list capacity; also the traverse loop bound.
- `ADDR_WIDTH`, `$clog2(MAX_NODE+1)`, derived; the all-ones address is NULL.
- `WDOG_CYCLES`, 64, `op_done` timeout; used only when the watchdog is compiled in.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: host command valid.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 0 traverse; 1 delete value; 2 push back; 3 push front.
- `cmd_data` in DATA_WIDTH: value for ops 1–3.
- `rd_valid` out 1, `rd_ready` in 1: traverse stream handshake.
- `rd_data` out DATA_WIDTH, `rd_last` out 1: node data; `rd_last` marks the tail node.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_fault` out 1: qualified by `resp_valid`.
- `resp_count` out ADDR_WIDTH: nodes streamed, qualified by `resp_valid`.
- `ll_op` out 2, `ll_data_in` out DATA_WIDTH, `ll_addr_in` out ADDR_WIDTH, `ll_op_start` out 1: to the list.
- `ll_data_out` in DATA_WIDTH, `ll_next_node_addr` in ADDR_WIDTH, `ll_op_done` in 1, `ll_head` in ADDR_WIDTH, `ll_empty` in 1, `ll_fault` in 1: from the list.

## Operation
- States: IDLE, ISSUE, STREAM, RESP.
- **IDLE.**
  - `cmd_ready=1`.
  - On `cmd_valid`, latch op and data.
  - Ops 1–3: go to ISSUE with `ll_op=cmd_op`, `ll_data_in=cmd_data`.
  - Op 0 with `ll_empty=1`: go straight to RESP with count 0 and fault 0; no list op is issued.
  - Op 0 otherwise: set `ll_addr_in=ll_head`, `ll_op=0`, go to ISSUE.
- **ISSUE.**
  - `ll_op_start=1`; `ll_op`, `ll_addr_in`, `ll_data_in` are held stable until `ll_op_done` is sampled high.
  - On `ll_op_done`, `ll_op_start` drops the next cycle. `ll_fault` sampled with `op_done` sets the fault flag.
  - Ops 1–3: go to RESP.
  - Op 0 without fault: register `ll_data_out` into `rd_data` and `ll_next_node_addr` into the next pointer. Set `rd_last = (next == NULL)`. Go to STREAM.
  - Op 0 with fault: go to RESP.
- **STREAM.**
  - `rd_valid=1`; `rd_data`/`rd_last` are held until `rd_ready`.
  - On handshake, count increments.
  - If `rd_last`: go to RESP.
  - Else if count == MAX_NODE: the list is corrupt or cyclic; set fault and go to RESP.
  - Else: `ll_addr_in=next`, go to ISSUE.
- **RESP.**
  - `resp_valid=1` for one cycle, with fault and count.
  - Return to IDLE; fault and count clear.
- Count saturates structurally at MAX_NODE, which fits ADDR_WIDTH.

## Timing
- Reset values:
  - `cmd_ready=0` during reset, 1 in the first cycle after reset.
  - All of `rd_valid`, `rd_last`, `rd_data`, `resp_valid`, `resp_fault`, `resp_count`, `ll_op_start`, `ll_op`, `ll_data_in` are 0.
  - `ll_addr_in` resets to NULL.
- Push/delete: command accepted at edge N; `ll_op_start` is high from N+1. If `ll_op_done` is sampled at edge M, then `ll_op_start` is low and `resp_valid` is high in cycle M+1. `cmd_ready` returns in M+2.
- `ll_op_start` is low for at least one cycle between consecutive list ops.
- Traverse, zero backpressure: per node, 1 ISSUE-to-done wait (list latency) + 1 STREAM cycle.
- Reset mid-operation: all state returns to IDLE at the next edge, and `ll_op_start` deasserts immediately. No `resp_valid` is emitted for the aborted command.
- Simultaneous `ll_op_done` and `rst`: reset wins.
- `cmd_valid` outside IDLE is ignored (`cmd_ready=0`).

## Configuration
- `LL_HOST_WATCHDOG_EN` defined:
  - A counter runs while `ll_op_start=1` and is cleared on entering ISSUE.
  - Reaching WDOG_CYCLES without `ll_op_done`: drop `ll_op_start`, set fault, go to RESP.
- Undefined: no counter; ISSUE waits for `ll_op_done` indefinitely.

## Test plan
- Reset, then push back 0x12, 0x34, and push front 0x56 -> three `resp_valid` pulses with `resp_fault=0`. Each `ll_op_start` is held until `op_done` and then dropped for one cycle or more.
- Traverse with `rd_ready=1` -> `rd_data` sequence 0x56, 0x12, 0x34; `rd_last` only on 0x34; `resp_count=3`, `resp_fault=0`.
- Traverse with `rd_ready` toggled 1/0 -> identical sequence; data is held stable while `rd_valid & !rd_ready`.
- Delete 0x99 (absent, list reports `ll_fault`) -> `resp_fault=1`. A following traverse is still 0x56, 0x12, 0x34.
- Traverse on an empty list -> `resp_valid` with count 0; no `ll_op_start`, no `rd_valid`. A stubbed cyclic list (next never NULL) -> exactly 8 beats, `resp_fault=1`.
- With `LL_HOST_WATCHDOG_EN` and a stub that never asserts `op_done` -> `resp_fault=1` exactly WDOG_CYCLES after `ll_op_start` rises. Assert `rst` mid-traverse -> all outputs take reset values next cycle, and no `resp_valid`.
